booth_mul_seq: RTL and testbench

- Sequential radix-4 Booth multiplier for signed 32x32 operands, giving a 64-bit product.
- Sits directly upstream of the ALU result path. The alu launches it for opcode 5'b01111 (mul), and its 64-bit product feeds the ALU 64-bit result, which is split into HI = [63:32] and LO = [31:0].
- Replaces a single-cycle combinational multiply with a 16-iteration datapath and a start/done handshake.

---
 rtl/booth_mul_seq_if.sv | 22 ++
 rtl/booth_mul_seq.sv | 108 ++++++++++
 tb/tb_booth_mul_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_seq_if.sv
// Start/done handshake and operand/product bus for the sequential Booth multiplier.
// The master launches operations; the slave (the multiplier) returns status and product.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, mcand, mplier,
        input  busy, done, product
    );

    modport slave (
        input  start, mcand, mplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product,
// one recoded digit per clock, start/done handshake, async active-low clear.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    booth_mul_seq_if.slave   bus
);
    localparam int ITER  = WIDTH / 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int AW    = WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic [AW-1:0]        mcand_q,   mcand_d;
    logic [AW-1:0]        acc_q,     acc_d;
    logic [WIDTH-1:0]     mq_q,      mq_d;
    logic                 prev_q,    prev_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [2:0]           triplet;
    logic [AW-1:0]        pp;
    logic [AW-1:0]        sum;

    // Multiplicand is held sign-extended to AW bits so that 2M and -2M of the
    // most negative operand still fit without overflow.
    always_comb begin
        triplet = {mq_q[1:0], prev_q};
        case (triplet)
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
        sum = acc_q + pp;
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mcand_d = {{2{bus.mcand[WIDTH-1]}}, bus.mcand};
                    acc_d   = '0;
                    mq_d    = bus.mplier;
                    prev_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                // {acc, mq} is the running product; arithmetic shift right by 2
                // retires one recoded digit while exposing the next triplet.
                acc_d  = {{2{sum[AW-1]}}, sum[AW-1:2]};
                mq_d   = {sum[1:0], mq_q[WIDTH-1:2]};
                prev_d = mq_q[1];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    product_d = {acc_d[WIDTH-1:0], mq_d};
                    state_d   = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == S_CALC);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomized self-checking bench for booth_mul_seq against a plain signed-multiply
// reference, covering handshake timing, back-to-back, ignored restart and async clear.
module tb_booth_mul_seq;
    logic clk;
    logic clr;
    int   n_checks;
    int   n_err;

    booth_mul_seq_if #(.WIDTH(32)) bus ();

    booth_mul_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corner [4];
        corner[0] = 32'h8000_0000;
        corner[1] = 32'h7FFF_FFFF;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h0000_0000;
        if ($urandom_range(3) == 0) return corner[$urandom_range(3)];
        return $urandom;
    endfunction

    // Called just after a rising edge. Launches one operation, scrambles the
    // operands after sampling, optionally re-pulses start mid-calculation.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int repulse, input string tag);
        int busy_cycles;
        int lat;
        int both;
        busy_cycles = 0;
        lat = -1;
        both = 0;
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.mcand  = $urandom;
        bus.mplier = $urandom;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busy_cycles++;
            if (bus.busy && bus.done) both++;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (k == repulse) begin
                bus.start  = 1'b1;
                bus.mcand  = $urandom;
                bus.mplier = $urandom;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'd16);
        chk({tag, " busy_cycles"}, 64'(busy_cycles), 64'd16);
        chk({tag, " busy_and_done"}, 64'(both), 64'd0);
        chk({tag, " product"}, bus.product, exp);
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, {63'd0, bus.done}, 64'd0);
        chk({tag, " product_held"}, bus.product, exp);
    endtask

    initial begin
        int d1;
        int d2;
        int seen;
        logic [31:0] a;
        logic [31:0] b;
        n_checks   = 0;
        n_err      = 0;
        clr        = 1'b0;
        bus.start  = 1'b0;
        bus.mcand  = '0;
        bus.mplier = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset product", bus.product, 64'd0);
        chk("reset busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        clr = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle product", bus.product, 64'd0);
            chk("idle busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        end
        @(posedge clk); #1;

        run_op(-32'sd750, 32'sd10, 64'hFFFF_FFFF_FFFF_E2B4, -1, "m750x10");
        chk("m750x10 HI", {32'd0, bus.product[63:32]}, 64'h0000_0000_FFFF_FFFF);
        chk("m750x10 LO", {32'd0, bus.product[31:0]},  64'h0000_0000_FFFF_E2B4);
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1, "minxmin");
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, -1, "maxxmax");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, -1, "m1xm1");
        run_op(32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, -1, "minx1");

        // Back-to-back: start held through DONE with new operands.
        d1 = -1;
        d2 = -1;
        bus.start  = 1'b1;
        bus.mcand  = 32'd3;
        bus.mplier = 32'd5;
        @(posedge clk); #1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (d1 >= 0 && k == d1 + 1) bus.start = 1'b0;
            if (bus.done) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk("b2b first product", bus.product, 64'h0000_0000_0000_000F);
                    bus.mcand  = -32'sd4;
                    bus.mplier = 32'sd6;
                end else begin
                    d2 = k;
                    chk("b2b second product", bus.product, 64'hFFFF_FFFF_FFFF_FFE8);
                    break;
                end
            end
        end
        bus.start = 1'b0;
        chk("b2b first latency", 64'(d1), 64'd16);
        chk("b2b spacing", 64'(d2 - d1), 64'd17);
        @(posedge clk); #1;
        chk("b2b back to idle", {62'd0, bus.busy, bus.done}, 64'd0);

        a = $urandom;
        b = $urandom;
        run_op(a, b, model(a, b), 5, "restart_ignored");

        // Asynchronous clear in the middle of iteration 8.
        bus.start  = 1'b1;
        bus.mcand  = 32'd12345;
        bus.mplier = -32'sd678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("abort busy before clr", {63'd0, bus.busy}, 64'd1);
        clr = 1'b0;
        #1;
        chk("abort product", bus.product, 64'd0);
        chk("abort busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr  = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("abort no done", 64'(seen), 64'd0);
        @(posedge clk); #1;
        run_op(32'd12345, -32'sd678, model(32'd12345, -32'sd678), -1, "after_abort");

        for (int i = 0; i < 24; i++) begin
            a = pick();
            b = pick();
            run_op(a, b, model(a, b), -1, "random");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
